decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage -- RV32I instruction decode stage with ID/EX pipeline register
//
// Decodes the instruction held in IF/ID, reads operands from the external
// register file (with a same-cycle writeback bypass), detects load-use
// hazards and registers all control and datapath fields into ID/EX.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   InstrD, PCD, PCPlus4D       instruction and its PC / PC+4 from IF/ID
//   ValidD                      InstrD holds a real instruction
//   A1, A2                      register-file read addresses (combinational)
//   RD1, RD2                    register-file read data for A1 / A2
//   RegWriteW, RDW, ResultW     writeback port (used here for bypassing)
//   FlushE                      kill the instruction in D (taken branch/jump)
//   StallD                      load-use hazard, hold PC and IF/ID
//   *E outputs                  registered ID/EX pipeline fields
// ---------------------------------------------------------------------------
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        ValidD,
    output logic [4:0]  A1,
    output logic [4:0]  A2,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        StallD,
    output logic        ValidE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic        JumpE,
    output logic        ALUSrcE,
    output logic        IllegalE,
    output logic [1:0]  ResultSrcE,
    output logic [3:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RS1E,
    output logic [4:0]  RS2E,
    output logic [4:0]  RDE
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // ALU operation for R-type and I-ALU. funct7[5] selects SUB only for
    // R-type (ADDI has immediate bits there); it selects SRA for both.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                  input logic       f7b5,
                                                  input logic       is_rtype);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [1:0][4:0]  rs_addr;
    logic [1:0][31:0] rf_data;
    logic [1:0][31:0] operand_next;

    assign opcode     = InstrD[6:0];
    assign rs_addr[0] = InstrD[19:15];
    assign rs_addr[1] = InstrD[24:20];
    assign rf_data[0] = RD1;
    assign rf_data[1] = RD2;
    assign A1         = rs_addr[0];
    assign A2         = rs_addr[1];

    // Writeback bypass: the register file is written on the same edge that
    // ID/EX captures, so forward ResultW when it targets a source register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            assign operand_next[gi] =
                (RegWriteW && (RDW != 5'd0) && (RDW == rs_addr[gi])) ? ResultW : rf_data[gi];
        end
    endgenerate

    // Load-use hazard: deliberately independent of the opcode in D, so an
    // instruction that ignores rs2 may still stall on a match.
    assign StallD = ValidE && (ResultSrcE == 2'b01) && (RDE != 5'd0) &&
                    ((RDE == rs_addr[0]) || (RDE == rs_addr[1]));

    logic        reg_write_next, mem_write_next, branch_next, jump_next;
    logic        alu_src_next, illegal_next, lui_next;
    logic [1:0]  result_src_next;
    logic [3:0]  alu_ctl_next;
    logic [31:0] imm_next;

    always_comb begin
        reg_write_next  = 1'b0;
        mem_write_next  = 1'b0;
        branch_next     = 1'b0;
        jump_next       = 1'b0;
        alu_src_next    = 1'b0;
        illegal_next    = 1'b0;
        lui_next        = 1'b0;
        result_src_next = 2'b00;
        alu_ctl_next    = ALU_ADD;
        imm_next        = 32'd0;
        case (opcode)
            OP_R: begin
                reg_write_next = 1'b1;
                alu_ctl_next   = alu_from_funct(InstrD[14:12], InstrD[30], 1'b1);
            end
            OP_IMM: begin
                reg_write_next = 1'b1;
                alu_src_next   = 1'b1;
                alu_ctl_next   = alu_from_funct(InstrD[14:12], InstrD[30], 1'b0);
                imm_next       = {{20{InstrD[31]}}, InstrD[31:20]};
            end
            OP_LOAD: begin
                reg_write_next  = 1'b1;
                alu_src_next    = 1'b1;
                result_src_next = 2'b01;
                imm_next        = {{20{InstrD[31]}}, InstrD[31:20]};
            end
            OP_STORE: begin
                mem_write_next = 1'b1;
                alu_src_next   = 1'b1;
                imm_next       = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            end
            OP_BRANCH: begin
                branch_next  = 1'b1;
                alu_ctl_next = ALU_SUB;
                imm_next     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            end
            OP_JAL: begin
                reg_write_next  = 1'b1;
                jump_next       = 1'b1;
                result_src_next = 2'b10;
                imm_next        = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            end
            OP_LUI: begin
                reg_write_next = 1'b1;
                alu_src_next   = 1'b1;
                lui_next       = 1'b1;
                imm_next       = {InstrD[31:12], 12'h000};
            end
            default: illegal_next = 1'b1;
        endcase
        // An empty slot carries no side effects and cannot be illegal.
        if (!ValidD) begin
            reg_write_next = 1'b0;
            mem_write_next = 1'b0;
            branch_next    = 1'b0;
            jump_next      = 1'b0;
            alu_src_next   = 1'b0;
            illegal_next   = 1'b0;
        end
    end

    logic bubble;
    assign bubble = FlushE || StallD;

    // Control half of ID/EX: flush and stall both insert a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ALUSrcE     <= 1'b0;
            IllegalE    <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= ALU_ADD;
        end else if (bubble) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ALUSrcE     <= 1'b0;
            IllegalE    <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= ALU_ADD;
        end else begin
            ValidE      <= ValidD;
            RegWriteE   <= reg_write_next;
            MemWriteE   <= mem_write_next;
            BranchE     <= branch_next;
            JumpE       <= jump_next;
            ALUSrcE     <= alu_src_next;
            IllegalE    <= illegal_next;
            ResultSrcE  <= result_src_next;
            ALUControlE <= alu_ctl_next;
        end
    end

    // Datapath half of ID/EX: contents are don't-care behind a bubble, so
    // it simply holds instead of being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            RD1E     <= 32'd0;
            RD2E     <= 32'd0;
            ImmExtE  <= 32'd0;
            PCE      <= 32'd0;
            PCPlus4E <= 32'd0;
            RS1E     <= 5'd0;
            RS2E     <= 5'd0;
            RDE      <= 5'd0;
        end else if (!bubble) begin
            RD1E     <= lui_next ? 32'd0 : operand_next[0];
            RD2E     <= operand_next[1];
            ImmExtE  <= imm_next;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            RS1E     <= rs_addr[0];
            RS2E     <= rs_addr[1];
            RDE      <= InstrD[11:7];
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage -- self-checking bench for decode_stage
//
// Directed table of known encodings, hand-written hazard / flush / reset
// sequences, then randomized traffic against a behavioural model of the
// ID/EX register.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        StallD;
    logic        ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RDE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .StallD(StallD), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUSrcE(ALUSrcE), .IllegalE(IllegalE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] instr, rd1, rd2;
        logic        validd, rww;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic        flush, ctl_only;
        logic [6:0]  e_ctl;   // {valid,regwrite,memwrite,branch,jump,alusrc,illegal}
        logic [1:0]  e_rs;
        logic [3:0]  e_alu;
        logic [31:0] e_rd1, e_rd2, e_imm;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[13];

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        valid, rw, mw, br, j, alusrc, ill;
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    exp_t m;
    logic [3:0] f3_op[8];   // ALU op by funct3 when funct7[5]=0

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic vd,
                                        input logic [31:0] r1, input logic [31:0] r2,
                                        input logic [31:0] pc, input logic [31:0] pc4,
                                        input logic rww, input logic [4:0] rdw,
                                        input logic [31:0] resw);
        exp_t e;
        logic [2:0] f3;
        logic       alt;
        e = '{default: '0};
        f3  = ins[14:12];
        alt = ins[30];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.pc  = pc;
        e.pc4 = pc4;
        e.rd1 = (rww && rdw != 0 && rdw == ins[19:15]) ? resw : r1;
        e.rd2 = (rww && rdw != 0 && rdw == ins[24:20]) ? resw : r2;
        e.alu = 4'b0000;
        case (ins[6:0])
            7'h33: begin
                e.rw = 1;
                e.alu = f3_op[f3];
                if (alt && f3 == 3'd0) e.alu = 4'b0001;
                if (alt && f3 == 3'd5) e.alu = 4'b1001;
            end
            7'h13: begin
                e.rw = 1; e.alusrc = 1;
                e.alu = f3_op[f3];
                if (alt && f3 == 3'd5) e.alu = 4'b1001;
                e.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'h03: begin
                e.rw = 1; e.alusrc = 1; e.rs = 2'b01;
                e.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'h23: begin
                e.mw = 1; e.alusrc = 1;
                e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'h63: begin
                e.br = 1; e.alu = 4'b0001;
                e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h6F: begin
                e.rw = 1; e.j = 1; e.rs = 2'b10;
                e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'h37: begin
                e.rw = 1; e.alusrc = 1;
                e.imm = {ins[31:12], 12'h000};
                e.rd1 = 32'd0;
            end
            default: e.ill = 1;
        endcase
        e.valid = vd;
        if (!vd) begin
            e.rw = 0; e.mw = 0; e.br = 0; e.j = 0; e.alusrc = 0; e.ill = 0;
        end
        return e;
    endfunction

    function automatic logic model_stall(input exp_t s, input logic [31:0] ins);
        return s.valid && s.rs == 2'b01 && s.rd != 0 &&
               (s.rd == ins[19:15] || s.rd == ins[24:20]);
    endfunction

    task automatic cmp_model(input logic full);
        chk("ValidE", {31'd0, ValidE}, {31'd0, m.valid});
        chk("ctl", {25'd0, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE},
                   {25'd0, m.rw, m.mw, m.br, m.j, m.alusrc, m.ill});
        if (full) begin
            chk("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, m.rs});
            chk("ALUControlE", {28'd0, ALUControlE}, {28'd0, m.alu});
            chk("RD1E", RD1E, m.rd1);
            chk("RD2E", RD2E, m.rd2);
            chk("ImmExtE", ImmExtE, m.imm);
            chk("PCE", PCE, m.pc);
            chk("PCPlus4E", PCPlus4E, m.pc4);
            chk("regs", {17'd0, RS1E, RS2E, RDE}, {17'd0, m.rs1, m.rs2, m.rd});
        end
    endtask

    task automatic idle_inputs();
        ValidD = 1'b1; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0; FlushE = 1'b0;
        PCD = 32'h100; PCPlus4D = 32'h104; RD1 = 32'd0; RD2 = 32'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ins;
        logic [6:0]  op;
        logic        s_exp, hold, full;

        f3_op[0] = 4'b0000; f3_op[1] = 4'b0111; f3_op[2] = 4'b0101; f3_op[3] = 4'b0110;
        f3_op[4] = 4'b0100; f3_op[5] = 4'b1000; f3_op[6] = 4'b0011; f3_op[7] = 4'b0010;

        //           instr         rd1          rd2        vd rww rdw resw        fl co  ctl        rs     alu      erd1         erd2   eimm          erd
        vecs[0]  = '{32'h002081B3, 32'd5,       32'd7,     1, 0, 0, 32'd0,        0, 0, 7'b1100000, 2'b00, 4'b0000, 32'd5,       32'd7, 32'd0,        5'd3};
        vecs[1]  = '{32'h002081B3, 32'd0,       32'd9,     1, 1, 1, 32'hDEADBEEF, 0, 0, 7'b1100000, 2'b00, 4'b0000, 32'hDEADBEEF, 32'd9, 32'd0,       5'd3};
        vecs[2]  = '{32'h002001B3, 32'h11,      32'd9,     1, 1, 0, 32'h12345678, 0, 0, 7'b1100000, 2'b00, 4'b0000, 32'h11,      32'd9, 32'd0,        5'd3};
        vecs[3]  = '{32'hFE000EE3, 32'd1,       32'd2,     1, 0, 0, 32'd0,        0, 0, 7'b1001000, 2'b00, 4'b0001, 32'd1,       32'd2, 32'hFFFFFFFC, 5'd29};
        vecs[4]  = '{32'h002081B3, 32'd5,       32'd7,     1, 0, 0, 32'd0,        1, 1, 7'b0000000, 2'b00, 4'b0000, 32'd0,       32'd0, 32'd0,        5'd0};
        vecs[5]  = '{32'h0000007F, 32'd5,       32'd7,     1, 0, 0, 32'd0,        0, 1, 7'b1000001, 2'b00, 4'b0000, 32'd0,       32'd0, 32'd0,        5'd0};
        vecs[6]  = '{32'h002081B3, 32'd5,       32'd7,     0, 0, 0, 32'd0,        0, 1, 7'b0000000, 2'b00, 4'b0000, 32'd0,       32'd0, 32'd0,        5'd0};
        vecs[7]  = '{32'h123452B7, 32'hAAAA,    32'd3,     1, 0, 0, 32'd0,        0, 0, 7'b1100010, 2'b00, 4'b0000, 32'd0,       32'd3, 32'h12345000, 5'd5};
        vecs[8]  = '{32'h0020A423, 32'd4,       32'd6,     1, 0, 0, 32'd0,        0, 0, 7'b1010010, 2'b00, 4'b0000, 32'd4,       32'd6, 32'd8,        5'd8};
        vecs[9]  = '{32'h40208233, 32'd4,       32'd6,     1, 0, 0, 32'd0,        0, 0, 7'b1100000, 2'b00, 4'b0001, 32'd4,       32'd6, 32'd0,        5'd4};
        vecs[10] = '{32'h4030D093, 32'd4,       32'd6,     1, 0, 0, 32'd0,        0, 0, 7'b1100010, 2'b00, 4'b1001, 32'd4,       32'd6, 32'h403,      5'd1};
        vecs[11] = '{32'h010000EF, 32'd4,       32'd6,     1, 0, 0, 32'd0,        0, 0, 7'b1100100, 2'b10, 4'b0000, 32'd4,       32'd6, 32'd16,       5'd1};
        vecs[12] = '{32'h0080A283, 32'd4,       32'd6,     1, 0, 0, 32'd0,        0, 0, 7'b1100010, 2'b01, 4'b0000, 32'd4,       32'd6, 32'd8,        5'd5};

        // ---- reset state ----
        rst = 1'b1; InstrD = 32'h002081B3; idle_inputs();
        @(negedge clk); @(negedge clk);
        chk("reset_ctl", {23'd0, ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE, ResultSrcE},
                         32'd0);
        chk("reset_alu", {28'd0, ALUControlE}, 32'd0);
        chk("reset_data", RD1E | RD2E | ImmExtE | PCE | PCPlus4E, 32'd0);
        chk("reset_regs", {17'd0, RS1E, RS2E, RDE}, 32'd0);
        chk("reset_stall", {31'd0, StallD}, 32'd0);
        rst = 1'b0;

        // ---- directed table ----
        for (int i = 0; i < 13; i++) begin
            InstrD = vecs[i].instr; RD1 = vecs[i].rd1; RD2 = vecs[i].rd2;
            ValidD = vecs[i].validd; RegWriteW = vecs[i].rww; RDW = vecs[i].rdw;
            ResultW = vecs[i].resw; FlushE = vecs[i].flush;
            PCD = 32'h1000 + 32'(i * 4); PCPlus4D = 32'h1004 + 32'(i * 4);
            #1;
            chk($sformatf("v%0d_A1A2", i), {22'd0, A1, A2}, {22'd0, vecs[i].instr[19:15], vecs[i].instr[24:20]});
            chk($sformatf("v%0d_stall", i), {31'd0, StallD}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ctl", i),
                {25'd0, ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE},
                {25'd0, vecs[i].e_ctl});
            if (!vecs[i].ctl_only) begin
                chk($sformatf("v%0d_rs_alu", i), {26'd0, ResultSrcE, ALUControlE}, {26'd0, vecs[i].e_rs, vecs[i].e_alu});
                chk($sformatf("v%0d_RD1E", i), RD1E, vecs[i].e_rd1);
                chk($sformatf("v%0d_RD2E", i), RD2E, vecs[i].e_rd2);
                chk($sformatf("v%0d_ImmExtE", i), ImmExtE, vecs[i].e_imm);
                chk($sformatf("v%0d_RDE", i), {27'd0, RDE}, {27'd0, vecs[i].e_rd});
                chk($sformatf("v%0d_PCE", i), PCE, 32'h1000 + 32'(i * 4));
            end
            @(negedge clk);
        end

        // ---- load-use: LW x5 now in EX, ADD x6,x5,x2 in D ----
        idle_inputs(); InstrD = 32'h00228333;
        #1 chk("lu_stall_on", {31'd0, StallD}, 32'd1);
        @(posedge clk); #1;
        chk("lu_bubble", {30'd0, ValidE, RegWriteE}, 32'd0);
        chk("lu_stall_off", {31'd0, StallD}, 32'd0);
        @(negedge clk); @(posedge clk); #1;
        chk("lu_capture", {30'd0, ValidE, RegWriteE}, 32'd3);
        chk("lu_regs", {22'd0, RS1E, RDE}, {22'd0, 5'd5, 5'd6});
        @(negedge clk);

        // ---- flush concurrent with hazard ----
        InstrD = 32'h0080A283;
        @(posedge clk); @(negedge clk);
        InstrD = 32'h00228333; FlushE = 1'b1;
        #1 chk("fh_stall", {31'd0, StallD}, 32'd1);
        @(posedge clk); #1;
        chk("fh_bubble", {31'd0, ValidE}, 32'd0);
        @(negedge clk); FlushE = 1'b0;

        // ---- reset held two cycles mid-stream ----
        InstrD = 32'h002081B3; RD1 = 32'd5; RD2 = 32'd7;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d_ctl", c),
                {21'd0, ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE},
                32'd0);
            chk($sformatf("rst%0d_data", c), RD1E | RD2E | ImmExtE | PCE | PCPlus4E | {17'd0, RS1E, RS2E, RDE}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b0; InstrD = 32'h000013B7;
        @(posedge clk); #1;
        chk("post_rst_capture", {ValidE, RegWriteE, 25'd0, RDE}, {1'b1, 1'b1, 25'd0, 5'd7});
        chk("post_rst_imm", ImmExtE, 32'h00001000);
        @(negedge clk);

        // ---- randomized traffic against the model ----
        rst = 1'b1;
        @(posedge clk); #1;
        m = '{default: '0};
        cmp_model(1'b1);
        @(negedge clk);
        rst = 1'b0;
        hold = 1'b0;
        ins = 32'd0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                case ($urandom_range(0, 9))
                    0: op = 7'h33;  1: op = 7'h13;  2, 3: op = 7'h03;
                    4: op = 7'h23;  5: op = 7'h63;  6: op = 7'h6F;  7: op = 7'h37;
                    8: op = 7'h33;
                    default: begin
                        do op = 7'($urandom_range(0, 127));
                        while (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37});
                    end
                endcase
                ins = $urandom;
                ins[6:0]   = op;
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
            end
            InstrD = ins;
            ValidD = ($urandom_range(0, 9) != 0);
            RD1 = $urandom; RD2 = $urandom;
            PCD = $urandom; PCPlus4D = PCD + 32'd4;
            RegWriteW = $urandom_range(0, 1) == 1;
            RDW = 5'($urandom_range(0, 3));
            ResultW = $urandom;
            FlushE = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            s_exp = model_stall(m, ins);
            #1;
            chk("rnd_stall", {31'd0, StallD}, {31'd0, s_exp});
            chk("rnd_A1A2", {22'd0, A1, A2}, {22'd0, ins[19:15], ins[24:20]});
            @(posedge clk);
            if (rst) begin
                m = '{default: '0};
            end else if (FlushE || s_exp) begin
                m.valid = 0; m.rw = 0; m.mw = 0; m.br = 0; m.j = 0; m.alusrc = 0; m.ill = 0; m.rs = 2'b00;
            end else begin
                m = ref_decode(ins, ValidD, RD1, RD2, PCD, PCPlus4D, RegWriteW, RDW, ResultW);
            end
            full = rst || m.valid;
            #1 cmp_model(full);
            hold = s_exp && !FlushE && !rst;
            @(negedge clk);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
